note_scroller: RTL and testbench
================================

Name: note_scroller

Overview:
Consumes the single-cycle step tick from the speed-programmable enable divider and scrolls a LANES x DEPTH grid of arrow notes one row toward the target row on every tick. It injects new notes at the top, judges player key presses against the bottom two rows, and emits per-lane hit/miss pulses plus saturating score and streak counters. The grid feeds the LED/VGA renderer; the counters feed the HEX score display.

Parameters:
LANES, 4, number of arrow lanes (one key per lane)
DEPTH, 16, grid rows; row 0 = top (spawn), row DEPTH-1 = target row
SCORE_W, 10, score counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en  in  1  one-cycle step tick from the enable divider
run  in  1  game active; 0 freezes the grid and ignores keys
clear  in  1  synchronous clear of grid, score and streak
spawn  in  LANES  notes to inject into row 0, sampled only on an active step
key  in  LANES  raw player keys, active-high level, already synchronised
grid  out  DEPTH*LANES  registered note grid, row r at bits [r*LANES +: LANES]
hit_lanes  out  LANES  one-cycle pulse per lane judged a hit
miss_lanes  out  LANES  one-cycle pulse per lane missed (scrolled off) or wrong press
score  out  SCORE_W  total hits, saturating at 2^SCORE_W-1
streak  out  8  consecutive hits since the last miss, saturating at 255

Behaviour:
- Reset (reset=0, asynchronous): grid=0, hit_lanes=0, miss_lanes=0, score=0, streak=0, key history=all ones (a key held through reset yields no press).
- Press detect: press[l] = key[l] & ~key_q[l]; key_q updates every cycle regardless of run.
- Active step: step = en & run. Judging: judge = press & {LANES{run}}.
- Judging per lane l with judge[l], using the pre-update grid:
  - grid[DEPTH-1][l]=1 -> hit; cell cleared.
  - else grid[DEPTH-2][l]=1 -> hit (early window); cell cleared.
  - else -> wrong press; miss_lanes[l] pulses.
  - Only one cell is cleared per press; the bottom row has priority.
- Update order within one cycle: judging clears first, then shift if step:
  - grid[0] <= spawn; grid[r] <= cleared grid[r-1] for r = 1..DEPTH-1.
  - Bits of cleared grid[DEPTH-1] that are still set -> scroll-off miss in those lanes.
- Simultaneous press and step:
  - A note in the target row pressed in the same cycle counts as a hit, not a miss.
  - A note in row DEPTH-2 pressed in the same cycle is cleared and does not advance.
- hit_lanes and miss_lanes are registered. Latency: one cycle after the judging/step cycle, high for exactly one cycle. miss_lanes = wrong-press OR scroll-off.
- score <= min(score + popcount(hit), max). Several lanes hit together add several points.
- streak:
  - If any miss bit is set that cycle, streak <= 0. Hits in the same cycle still add to score but not to streak.
  - Otherwise streak <= min(streak + popcount(hit), 255).
- run=0: grid, score and streak hold. No judging, no pulses. en is ignored.
- clear=1: grid, score, streak and pulse registers go to 0 next edge. clear has priority over step and judging. key_q still updates.
- en asserted for consecutive cycles: each cycle is an independent step, with no rate limiting.
- Reset mid-game: all state returns to reset values immediately. Pulses in flight are dropped.

Decomposition:
- Package ddr_pkg:
  - localparams N_LANES=4, GRID_DEPTH=16, SCORE_W=10, STREAK_MAX=255.
  - typedef lane_t = logic [N_LANES-1:0].
  - popcount function for lane_t.
- Sub-module key_edge: per-lane rising-edge detector, with clk, reset (async active-low, history resets to ones), key in, press out. Reused by the menu logic.
- Grid shift, judging, scoring and streak stay in note_scroller.

Test Plan:
- Reset with key=4'b1111 held, release, wait 3 cycles -> no miss_lanes pulse; grid=0, score=0.
- run=1, spawn=4'b0001 on one en, then 15 more en pulses with spawn=0, no keys -> note reaches row 15 after 15 steps. On step 16, miss_lanes=4'b0001 for one cycle the next cycle; streak=0.
- Note in lane 2 at row 15, rising edge on key[2] -> hit_lanes=4'b0100 one cycle later; score 0->1, streak 0->1, cell cleared. Repeat with the note at row 14 -> also a hit.
- key[3] press with lane 3 empty in rows 14-15 and streak=5 -> miss_lanes=4'b1000 and streak=0; score unchanged.
- Notes in lanes 0 and 1 at row 15, press both in the same cycle as en -> hit_lanes=4'b0011, score += 2, no miss pulse.
- score preloaded to 1023 by repeated hits, one more hit -> score stays 1023. Then assert run=0 and pulse en -> grid unchanged. Then assert clear -> grid, score and streak all 0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared constants and helpers for the arrow-note game: lane/grid sizing,
// the lane bit-vector type and a population count for lane vectors.
package ddr_pkg;

  localparam int N_LANES    = 4;
  localparam int GRID_DEPTH = 16;
  localparam int SCORE_W    = 10;
  localparam int STREAK_MAX = 255;

  localparam int CNT_W = $clog2(N_LANES + 1);

  typedef logic [N_LANES-1:0] lane_t;
  typedef logic [CNT_W-1:0]   lane_cnt_t;

  function automatic lane_cnt_t popcount(input lane_t v);
    lane_cnt_t n;
    n = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n = n + lane_cnt_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/note_scroller_key_edge.sv
// Per-lane rising-edge detector for already-synchronised key levels.
// History resets to all ones so a key held through reset produces no press.
module key_edge
  import ddr_pkg::*;
#(
  parameter int W = N_LANES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] key,
  output logic [W-1:0] press
);

  logic [W-1:0] key_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= '1;
    end else begin
      key_q <= key;
    end
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/note_scroller.sv
// Scrolls a LANES x DEPTH note grid toward the target row on each step tick,
// judges key presses against the bottom two rows and keeps score and streak.
module note_scroller
  import ddr_pkg::*;
#(
  parameter int LANES   = N_LANES,
  parameter int DEPTH   = GRID_DEPTH,
  parameter int SCORE_W = ddr_pkg::SCORE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   run,
  input  logic                   clear,
  input  logic [LANES-1:0]       spawn,
  input  logic [LANES-1:0]       key,
  output logic [DEPTH*LANES-1:0] grid,
  output logic [LANES-1:0]       hit_lanes,
  output logic [LANES-1:0]       miss_lanes,
  output logic [SCORE_W-1:0]     score,
  output logic [7:0]             streak
);

  localparam int HIT_CNT_W = $clog2(LANES + 1);

  // Row r of the packed array sits at bits [r*LANES +: LANES] of grid.
  logic [DEPTH-1:0][LANES-1:0] rows;
  logic [DEPTH-1:0][LANES-1:0] rows_judged;
  logic [DEPTH-1:0][LANES-1:0] rows_next;

  logic [LANES-1:0]     press;
  logic [LANES-1:0]     judge;
  logic [LANES-1:0]     hit;
  logic [LANES-1:0]     wrong;
  logic [LANES-1:0]     scroll_off;
  logic [LANES-1:0]     miss;
  logic                 step;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;
  logic [8:0]           streak_sum;
  logic [7:0]           streak_next;

  key_edge #(
    .W (LANES)
  ) u_key_edge (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .press (press)
  );

  assign step  = en & run;
  assign judge = press & {LANES{run}};

  // Judging clears at most one cell per lane (bottom row first), then the
  // step shifts the judged grid so a note hit in row DEPTH-2 never advances.
  // NOTE: every signal driven here gets a default at the top of the block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rows_judged = rows;
    hit         = '0;
    wrong       = '0;
    for (int l = 0; l < LANES; l++) begin
      if (judge[l]) begin
        if (rows[DEPTH-1][l]) begin
          hit[l]                  = 1'b1;
          rows_judged[DEPTH-1][l] = 1'b0;
        end else if (rows[DEPTH-2][l]) begin
          hit[l]                  = 1'b1;
          rows_judged[DEPTH-2][l] = 1'b0;
        end else begin
          wrong[l] = 1'b1;
        end
      end
    end

    scroll_off = '0;
    rows_next  = rows_judged;
    if (step) begin
      scroll_off = rows_judged[DEPTH-1];
      for (int r = 1; r < DEPTH; r++) begin
        rows_next[r] = rows_judged[r-1];
      end
      rows_next[0] = spawn;
    end

    miss = wrong | scroll_off;
  end

  always_comb begin
    hit_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_cnt = hit_cnt + HIT_CNT_W'(hit[l]);
    end
  end

  // Both counters saturate; the extra sum bit flags overflow.
  always_comb begin
    score_sum  = {1'b0, score} + (SCORE_W + 1)'(hit_cnt);
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    streak_sum = {1'b0, streak} + 9'(hit_cnt);
    if (|miss) begin
      streak_next = '0;
    end else if (streak_sum > 9'(STREAK_MAX)) begin
      streak_next = 8'(STREAK_MAX);
    end else begin
      streak_next = streak_sum[7:0];
    end
  end

  // With run low, judge and step are both zero, so this update holds the grid
  // and counters and drives the pulse registers to zero.
  // NOTE: the grid is a small flop array, not a RAM, so it is reset like any
  // other state; clear is the synchronous counterpart with top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows       <= '0;
      hit_lanes  <= '0;
      miss_lanes <= '0;
      score      <= '0;
      streak     <= '0;
    end else if (clear) begin
      rows       <= '0;
      hit_lanes  <= '0;
      miss_lanes <= '0;
      score      <= '0;
      streak     <= '0;
    end else begin
      rows       <= rows_next;
      hit_lanes  <= hit;
      miss_lanes <= miss;
      score      <= score_next;
      streak     <= streak_next;
    end
  end

  assign grid = rows;

endmodule

// File: tb/tb_note_scroller.sv
// Directed and randomized bench for note_scroller, checked every cycle
// against a note-position model of the game rules.
module tb_note_scroller;
  import ddr_pkg::*;

  localparam int L  = N_LANES;
  localparam int D  = GRID_DEPTH;
  localparam int SW = SCORE_W;
  localparam int SCORE_MAX = (1 << SW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           run;
  logic           clear;
  logic [L-1:0]   spawn;
  logic [L-1:0]   key;
  logic [D*L-1:0] grid;
  logic [L-1:0]   hit_lanes;
  logic [L-1:0]   miss_lanes;
  logic [SW-1:0]  score;
  logic [7:0]     streak;

  note_scroller dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .run        (run),
    .clear      (clear),
    .spawn      (spawn),
    .key        (key),
    .grid       (grid),
    .hit_lanes  (hit_lanes),
    .miss_lanes (miss_lanes),
    .score      (score),
    .streak     (streak)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: note occupancy per (row, lane) plus game counters.
  bit           occ [D][L];
  int           m_score;
  int           m_streak;
  logic [L-1:0] m_hit;
  logic [L-1:0] m_miss;
  logic [L-1:0] m_kprev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_grid();
    logic [63:0] g;
    g = '0;
    for (int r = 0; r < D; r++)
      for (int l = 0; l < L; l++)
        g[r*L + l] = occ[r][l];
    return g;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < D; r++)
      for (int l = 0; l < L; l++)
        occ[r][l] = 1'b0;
    m_score  = 0;
    m_streak = 0;
    m_hit    = '0;
    m_miss   = '0;
    m_kprev  = '1;
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [L-1:0] press;
    int           n;
    press   = key & ~m_kprev;
    m_kprev = key;
    if (clear) begin
      for (int r = 0; r < D; r++)
        for (int l = 0; l < L; l++)
          occ[r][l] = 1'b0;
      m_score  = 0;
      m_streak = 0;
      m_hit    = '0;
      m_miss   = '0;
      return;
    end
    m_hit  = '0;
    m_miss = '0;
    if (run) begin
      for (int l = 0; l < L; l++) begin
        if (press[l]) begin
          if (occ[D-1][l]) begin
            occ[D-1][l] = 1'b0;
            m_hit[l]    = 1'b1;
          end else if (occ[D-2][l]) begin
            occ[D-2][l] = 1'b0;
            m_hit[l]    = 1'b1;
          end else begin
            m_miss[l] = 1'b1;
          end
        end
      end
      if (en) begin
        for (int l = 0; l < L; l++)
          if (occ[D-1][l]) m_miss[l] = 1'b1;
        for (int r = D - 1; r > 0; r--)
          for (int l = 0; l < L; l++)
            occ[r][l] = occ[r-1][l];
        for (int l = 0; l < L; l++)
          occ[0][l] = spawn[l];
      end
    end
    n = $countones(m_hit);
    m_score  = (m_score + n > SCORE_MAX) ? SCORE_MAX : m_score + n;
    m_streak = (m_miss != 0) ? 0 : ((m_streak + n > 255) ? 255 : m_streak + n);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".grid"},   64'(grid),       model_grid());
    check({tag, ".hit"},    64'(hit_lanes),  64'(m_hit));
    check({tag, ".miss"},   64'(miss_lanes), 64'(m_miss));
    check({tag, ".score"},  64'(score),      64'(m_score));
    check({tag, ".streak"}, 64'(streak),     64'(m_streak));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Spawns notes in mask, then steps them down to the given row.
  task automatic place(input logic [L-1:0] mask, input int row);
    en    = 1'b1;
    spawn = mask;
    cycle("place");
    spawn = '0;
    repeat (row) cycle("place");
    en = 1'b0;
  endtask

  task automatic release_keys();
    key = '0;
    en  = 1'b0;
    cycle("release");
  endtask

  initial begin
    logic [63:0] frozen;

    reset = 1'b0;
    en    = 1'b0;
    run   = 1'b0;
    clear = 1'b0;
    spawn = '0;
    key   = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");

    // Keys held through reset release must not register as presses.
    reset = 1'b1;
    run   = 1'b1;
    repeat (3) cycle("held");
    check("held.no_miss", 64'(miss_lanes), 64'h0);
    check("held.score", 64'(score), 64'h0);
    release_keys();

    // A lone note scrolls to the target row, then off it as a miss.
    place(4'b0001, 15);
    check("scroll.row15", 64'(grid), 64'h1 << ((D - 1) * L));
    en = 1'b1;
    cycle("scroll");
    check("scroll.miss", 64'(miss_lanes), 64'h1);
    check("scroll.streak", 64'(streak), 64'h0);
    en = 1'b0;
    cycle("scroll");
    check("scroll.miss_gone", 64'(miss_lanes), 64'h0);

    // Hit in the target row, then in the early-window row.
    place(4'b0100, 15);
    key = 4'b0100;
    cycle("hit15");
    check("hit15.hit", 64'(hit_lanes), 64'h4);
    check("hit15.score", 64'(score), 64'd1);
    check("hit15.streak", 64'(streak), 64'd1);
    check("hit15.grid", 64'(grid), 64'h0);
    release_keys();
    place(4'b0100, 14);
    key = 4'b0100;
    cycle("hit14");
    check("hit14.hit", 64'(hit_lanes), 64'h4);
    check("hit14.score", 64'(score), 64'd2);
    release_keys();
    for (int i = 0; i < 3; i++) begin
      place(4'b0001, 15);
      key = 4'b0001;
      cycle("streak");
      release_keys();
    end
    check("streak.five", 64'(streak), 64'd5);

    // Wrong press on an empty lane breaks the streak, score untouched.
    key = 4'b1000;
    cycle("wrong");
    check("wrong.miss", 64'(miss_lanes), 64'h8);
    check("wrong.streak", 64'(streak), 64'd0);
    check("wrong.score", 64'(score), 64'd5);
    release_keys();

    // Two-lane hit on the same cycle as a step: hits, no scroll-off miss.
    place(4'b0011, 15);
    key = 4'b0011;
    en  = 1'b1;
    cycle("dual");
    check("dual.hit", 64'(hit_lanes), 64'h3);
    check("dual.miss", 64'(miss_lanes), 64'h0);
    check("dual.score", 64'(score), 64'd7);
    release_keys();

    // Fill every lane each step and hit the target row in between, to
    // drive score and streak into saturation.
    for (int i = 0; i < 2000 && m_score < SCORE_MAX; i++) begin
      key = '1; en = 1'b0; spawn = '0;
      cycle("sat");
      key = '0; en = 1'b1; spawn = '1;
      cycle("sat");
    end
    key = '1; en = 1'b0; spawn = '0;
    cycle("sat_top");
    check("sat.score", 64'(score), 64'(SCORE_MAX));
    check("sat.streak", 64'(streak), 64'd255);
    check("sat.hit", 64'(hit_lanes), 64'hf);
    key = '0;

    // run low freezes everything and ignores en, spawn and keys.
    run    = 1'b0;
    frozen = model_grid();
    en     = 1'b1;
    spawn  = 4'b1010;
    cycle("frozen");
    key = 4'b0101;
    cycle("frozen");
    check("frozen.grid", 64'(grid), frozen);
    check("frozen.hit", 64'(hit_lanes), 64'h0);
    check("frozen.score", 64'(score), 64'(SCORE_MAX));

    // Synchronous clear wins over step and judging.
    run   = 1'b1;
    clear = 1'b1;
    key   = 4'b1010;
    cycle("clear");
    check("clear.grid", 64'(grid), 64'h0);
    check("clear.score", 64'(score), 64'h0);
    check("clear.streak", 64'(streak), 64'h0);
    clear = 1'b0;
    key   = '0;
    en    = 1'b0;
    spawn = '0;
    cycle("post_clear");

    // Asynchronous reset in mid-game drops the grid and pulses at once.
    place(4'b0110, 15);
    key = 4'b0110;
    cycle("pre_reset");
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    key   = '0;
    cycle("after_reset");

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      en    = 1'($urandom_range(0, 1));
      run   = ($urandom_range(0, 15) != 0);
      clear = ($urandom_range(0, 199) == 0);
      spawn = L'($urandom_range(0, 15) & $urandom_range(0, 15));
      key   = L'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
